// File: rtl/alu_cmd_sender_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_sender_if
//   Byte-level link between the command-frame sender and uart_basic.
//
//   tx_data  [7:0] byte to transmit
//   tx_start       one-cycle send strobe
//   tx_busy        transmitter busy
//   rx_data  [7:0] received byte
//   rx_ready       one-cycle strobe, rx_data valid
//
//   master : the frame sender (drives tx_data/tx_start)
//   slave  : the UART side (drives tx_busy/rx_data/rx_ready)
// ---------------------------------------------------------------------------
interface alu_cmd_sender_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  rx_data,
        input  rx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output rx_data,
        output rx_ready
    );
endinterface

// File: rtl/alu_cmd_sender.sv
// ---------------------------------------------------------------------------
// alu_cmd_sender
//   Command-frame initiator for the UART calculator link. On an accepted
//   start it sends five bytes (op1 lo/hi, op2 lo/hi, opcode) through the
//   uart_basic byte interface, then collects the two-byte result reply.
//   A reply that stalls for TIMEOUT_CYCLES cycles aborts with a timeout.
//
// Ports
//   CLK100MHZ         clock, rising edge
//   CPU_RESETN        asynchronous active-low reset
//   start             one-cycle frame request, ignored while busy
//   op1, op2 [15:0]   operands, captured on accepted start
//   alu_ctrl [2:0]    opcode, captured on accepted start
//   uart              byte link to uart_basic (master side)
//   busy              accepted start .. result_valid/timeout pulse
//   result   [15:0]   last complete reply, held otherwise
//   result_valid      one-cycle pulse when result updates
//   timeout           one-cycle pulse on reply timeout
//   state    [3:0]    FSM encoding for LED debug
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// SEND  | strobe byte idx once tx_busy is low
// W_RISE| wait for the UART to report busy
// W_FALL| wait for the UART to finish; advance idx
// RX_LO | wait for reply low byte (timed)
// RX_HI | wait for reply high byte (timed)
// DONE  | one-cycle result_valid
// TOUT  | one-cycle timeout
// ---------------------------------------------------------------------------
module alu_cmd_sender #(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              start,
    input  logic [15:0]       op1,
    input  logic [15:0]       op2,
    input  logic [2:0]        alu_ctrl,
    alu_cmd_sender_if.master  uart,
    output logic              busy,
    output logic [15:0]       result,
    output logic              result_valid,
    output logic              timeout,
    output logic [3:0]        state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_WAIT_FALL = 3'd3,
        ST_RX_LO     = 3'd4,
        ST_RX_HI     = 3'd5,
        ST_DONE      = 3'd6,
        ST_TOUT      = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      op1_q, op1_d;
    logic [15:0]      op2_q, op2_d;
    logic [2:0]       alu_q, alu_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       lo_q, lo_d;
    logic [15:0]      result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]       frame_byte;
    logic             tx_start_c;
    logic             cnt_expired;

    always_comb begin
        case (idx_q)
            3'd0:    frame_byte = op1_q[7:0];
            3'd1:    frame_byte = op1_q[15:8];
            3'd2:    frame_byte = op2_q[7:0];
            3'd3:    frame_byte = op2_q[15:8];
            default: frame_byte = {5'b0, alu_q};
        endcase
    end

    assign cnt_expired = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        alu_d      = alu_q;
        tx_data_d  = tx_data_q;
        lo_d       = lo_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        tx_start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op1_d   = op1;
                    op2_d   = op2;
                    alu_d   = alu_ctrl;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Never strobe into a transmitter that is still busy.
                if (!uart.tx_busy) begin
                    tx_start_c = 1'b1;
                    tx_data_d  = frame_byte;
                    state_d    = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (uart.tx_busy) begin
                    state_d = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL: begin
                if (!uart.tx_busy) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_RX_LO;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_RX_LO: begin
                // A byte arriving on the last timed cycle still counts.
                if (uart.rx_ready) begin
                    lo_d    = uart.rx_data;
                    cnt_d   = '0;
                    state_d = ST_RX_HI;
                end else if (cnt_expired) begin
                    state_d = ST_TOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RX_HI: begin
                if (uart.rx_ready) begin
                    result_d = {uart.rx_data, lo_q};
                    state_d  = ST_DONE;
                end else if (cnt_expired) begin
                    state_d = ST_TOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_TOUT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            op1_q     <= 16'd0;
            op2_q     <= 16'd0;
            alu_q     <= 3'd0;
            tx_data_q <= 8'd0;
            lo_q      <= 8'd0;
            result_q  <= 16'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            alu_q     <= alu_d;
            tx_data_q <= tx_data_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end

    // The strobed byte is presented in the strobe cycle itself; between
    // strobes the register keeps the last byte sent.
    assign uart.tx_start = tx_start_c;
    assign uart.tx_data  = tx_start_c ? frame_byte : tx_data_q;

    assign busy         = (state_q != ST_IDLE);
    assign result       = result_q;
    assign result_valid = (state_q == ST_DONE);
    assign timeout      = (state_q == ST_TOUT);
    assign state        = {1'b0, state_q};

endmodule

// File: tb/tb_alu_cmd_sender.sv
module tb_alu_cmd_sender;
    localparam int T = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op1 = 16'd0;
    logic [15:0] op2 = 16'd0;
    logic [2:0]  alu_ctrl = 3'd0;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        timeout;
    logic [3:0]  state;

    alu_cmd_sender_if u_if ();

    alu_cmd_sender #(.TIMEOUT_CYCLES(T)) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .start        (start),
        .op1          (op1),
        .op2          (op2),
        .alu_ctrl     (alu_ctrl),
        .uart         (u_if),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name, input int got, input int want);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, phase %0d, wanted %0d", name, got, want);
    endtask

    // ---------------- UART transmitter model + byte scoreboard ----------------
    int         busy_len = 10;
    bit         force_busy = 1'b0;
    int         busy_left = 0;
    bit         uart_active = 1'b0;
    bit         pend = 1'b0;
    bit         drive_busy;
    int         total_done = 0;
    int         strobes = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sent_log[$];
    logic [7:0] last_byte = 8'd0;
    logic [7:0] e_byte;

    initial begin
        u_if.tx_busy  = 1'b0;
        u_if.rx_ready = 1'b0;
        u_if.rx_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_n && u_if.tx_start) begin
                strobes++;
                sent_log.push_back(u_if.tx_data);
                check("strobe_while_busy", 32'(u_if.tx_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    bound_fail("extra_strobe", strobes, 0);
                end else begin
                    e_byte = exp_q.pop_front();
                    check("tx_byte", 32'(u_if.tx_data), 32'(e_byte));
                    last_byte = e_byte;
                end
                pend = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pend) begin
                busy_left = busy_len;
                pend = 1'b0;
            end
            if (busy_left > 0) begin
                drive_busy = 1'b1;
                busy_left--;
                uart_active = 1'b1;
            end else begin
                drive_busy = 1'b0;
                if (uart_active) total_done++;
                uart_active = 1'b0;
            end
            u_if.tx_busy = force_busy || drive_busy;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // phase: 0 idle, 1 sending frame, 2 awaiting reply, 3 result pulse, 4 timeout pulse
    int          m_phase = 0;
    logic [15:0] m_result = 16'd0;
    logic [7:0]  m_low = 8'd0;
    bit          m_have_low = 1'b0;
    int          m_idle = 0;
    int          m_base = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase    = 0;
                m_result   = 16'd0;
                m_have_low = 1'b0;
                last_byte  = 8'd0;
                exp_q.delete();
            end
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("result", 32'(result), 32'(m_result));
            check("result_valid", 32'(result_valid), 32'(m_phase == 3));
            check("timeout", 32'(timeout), 32'(m_phase == 4));
            if (m_phase == 0) check("state_idle", 32'(state), 32'd0);
            if (m_phase == 3) check("state_done", 32'(state), 32'd6);
            if (m_phase == 4) check("state_tout", 32'(state), 32'd7);
            if (m_phase != 1) begin
                check("tx_start_quiet", 32'(u_if.tx_start), 32'd0);
                check("tx_data_hold", 32'(u_if.tx_data), 32'(last_byte));
            end
            if (rst_n) begin
                case (m_phase)
                    0: if (start) begin
                        exp_q.push_back(op1[7:0]);
                        exp_q.push_back(op1[15:8]);
                        exp_q.push_back(op2[7:0]);
                        exp_q.push_back(op2[15:8]);
                        exp_q.push_back({5'b0, alu_ctrl});
                        m_base  = total_done;
                        m_phase = 1;
                    end
                    1: if ((total_done - m_base) >= 5 && !u_if.tx_busy) begin
                        m_phase    = 2;
                        m_have_low = 1'b0;
                        m_idle     = 0;
                    end
                    2: if (u_if.rx_ready) begin
                        if (!m_have_low) begin
                            m_low      = u_if.rx_data;
                            m_have_low = 1'b1;
                            m_idle     = 0;
                        end else begin
                            m_result = {u_if.rx_data, m_low};
                            m_phase  = 3;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == T) m_phase = 4;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
        start = 1'b1;
        op1 = a;
        op2 = b;
        alu_ctrl = c;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        u_if.rx_data  = d;
        u_if.rx_ready = 1'b1;
        tick();
        u_if.rx_ready = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int limit, input string name);
        int k = 0;
        while (m_phase != p && k < limit) begin
            tick();
            k++;
        end
        if (m_phase != p) bound_fail(name, m_phase, p);
    endtask

    task automatic check_frame(input int first, input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] c, input string name);
        logic [7:0] want[5];
        logic [7:0] got;
        want[0] = a[7:0];
        want[1] = a[15:8];
        want[2] = b[7:0];
        want[3] = b[15:8];
        want[4] = {5'b0, c};
        for (int i = 0; i < 5; i++) begin
            got = (first + i < sent_log.size()) ? sent_log[first + i] : 8'hxx;
            check(name, 32'(got), 32'(want[i]));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int s0;
    int byte_edge;
    logic [15:0] ra, rb;
    logic [2:0]  rc;
    int mode;

    initial begin
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_start", 32'(u_if.tx_start), 32'd0);
        check("rst_tx_data", 32'(u_if.tx_data), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic frame and reply
        s0 = strobes;
        do_start(16'h1234, 16'h00AB, 3'd2);
        wait_phase(2, 400, "basic_frame");
        check("basic_strobes", 32'(strobes - s0), 32'd5);
        begin
            logic [7:0] lit[5];
            lit[0] = 8'h34; lit[1] = 8'h12; lit[2] = 8'hAB; lit[3] = 8'h00; lit[4] = 8'h02;
            for (int i = 0; i < 5; i++)
                check("basic_byte_lit", 32'(sent_log[s0 + i]), 32'(lit[i]));
        end
        tick(3);
        pulse_rx(8'hCD);
        tick(2);
        pulse_rx(8'h00);
        check("reply_valid_lit", 32'(result_valid), 32'd1);
        check("reply_result_lit", 32'(result), 32'h00CD);
        tick();
        check("reply_busy_low_lit", 32'(busy), 32'd0);
        check("reply_valid_single", 32'(result_valid), 32'd0);

        // Timeout after a single reply byte
        tick(2);
        do_start(16'h0102, 16'h0304, 3'd6);
        wait_phase(2, 400, "tout_frame");
        tick(4);
        byte_edge = cyc + 1;
        pulse_rx(8'h11);
        begin
            int k = 0;
            while (!timeout && k < 200) begin
                tick();
                k++;
            end
            if (!timeout) bound_fail("tout_wait", m_phase, 4);
        end
        check("tout_delay_lit", 32'(cyc - byte_edge), 32'd50);
        check("tout_result_lit", 32'(result), 32'h00CD);
        tick();
        check("tout_state_lit", 32'(state), 32'd0);

        // Busy gating: second start mid-frame ignored
        tick(2);
        s0 = strobes;
        do_start(16'hA5C3, 16'h0F0F, 3'd5);
        tick(3);
        do_start(16'hFFFF, 16'hFFFF, 3'd7);
        wait_phase(2, 400, "gate_frame");
        check("gate_strobes_lit", 32'(strobes - s0), 32'd5);
        check_frame(s0, 16'hA5C3, 16'h0F0F, 3'd5, "gate_byte");
        pulse_rx(8'h34);
        pulse_rx(8'h12);
        wait_phase(0, 20, "gate_idle");

        // tx_busy already high when the frame starts
        force_busy = 1'b1;
        tick(2);
        s0 = strobes;
        do_start(16'h5A5A, 16'h6B6B, 3'd3);
        tick(20);
        check("forced_no_strobe_lit", 32'(strobes - s0), 32'd0);
        force_busy = 1'b0;
        wait_phase(2, 400, "forced_frame");
        check("forced_strobes_lit", 32'(strobes - s0), 32'd5);
        pulse_rx(8'h00);
        pulse_rx(8'h00);
        wait_phase(0, 20, "forced_idle");

        // Stray RX during transmission
        tick(2);
        do_start(16'h2222, 16'h3333, 3'd4);
        tick(4);
        pulse_rx(8'h55);
        wait_phase(2, 400, "stray_frame");
        pulse_rx(8'h01);
        pulse_rx(8'h80);
        check("stray_result_lit", 32'(result), 32'h8001);
        wait_phase(0, 20, "stray_idle");

        // Reset in the middle of byte B2
        tick(2);
        s0 = strobes;
        do_start(16'hBEEF, 16'h1357, 3'd1);
        begin
            int k = 0;
            while ((strobes - s0) < 3 && k < 400) begin
                tick();
                k++;
            end
            if ((strobes - s0) < 3) bound_fail("rst_wait_b2", strobes - s0, 3);
        end
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_start", 32'(u_if.tx_start), 32'd0);
        check("midrst_tx_data", 32'(u_if.tx_data), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_state", 32'(state), 32'd0);
        tick(4);
        rst_n = 1'b1;
        tick(20);
        check("midrst_no_more_strobes", 32'(strobes - s0), 32'd3);
        s0 = strobes;
        do_start(16'hC0DE, 16'h4242, 3'd0);
        wait_phase(2, 400, "postrst_frame");
        check_frame(s0, 16'hC0DE, 16'h4242, 3'd0, "postrst_byte");
        pulse_rx(8'h78);
        pulse_rx(8'h56);
        wait_phase(0, 20, "postrst_idle");

        // Randomised transactions
        for (int it = 0; it < 25; it++) begin
            busy_len = int'($urandom_range(1, 12));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 3'($urandom);
            tick(int'($urandom_range(1, 4)));
            do_start(ra, rb, rc);
            if ($urandom_range(0, 1) == 1) begin
                tick(int'($urandom_range(0, 10)));
                do_start(16'($urandom), 16'($urandom), 3'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                tick(int'($urandom_range(1, 15)));
                if (m_phase == 1) pulse_rx(8'($urandom));
            end
            wait_phase(2, 400, "rand_frame");
            mode = int'($urandom_range(0, 3));
            tick(int'($urandom_range(0, 30)));
            if (mode != 1) pulse_rx(8'($urandom));
            if (mode >= 2) begin
                tick(int'($urandom_range(0, 30)));
                pulse_rx(8'($urandom));
            end
            wait_phase(0, 300, "rand_idle");
        end

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
